// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl: SPI mode-0 slave turning 32-bit host frames (33 with SPI_FRAME_PARITY_EN) into register reads/writes.
// Latency: pin edges act SYNC_STAGES+1 clk after the pin; o_addr 1 clk after bit 16, o_wr 1 clk after the last frame bit.
// Backpressure: none; the host must keep each SCLK phase >= 8 clk so read data is captured before falling edge 16.
module spi_frame_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        o_miso,
    output logic        o_miso_oe,
    output logic [15:0] o_addr,
    output logic [15:0] o_wdata,
    output logic        o_wr,
    input  logic [15:0] i_rdata,
    output logic        o_busy,
    output logic        o_frame_err
);

`ifdef SPI_FRAME_PARITY_EN
    localparam logic [5:0] FRAME_CNT = 6'd33;
`else
    localparam logic [5:0] FRAME_CNT = 6'd32;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_RD_WAIT,
        ST_DATA,
        ST_TAIL,
        ST_WAIT_CS
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q, cs_prev_d;
    state_t                 state_q, state_d;
    logic [5:0]             cnt_q, cnt_d;
    logic [15:0]            rx_q, rx_d;
    logic [15:0]            tx_q, tx_d;
    logic                   is_wr_q, is_wr_d;
    logic                   wait_q, wait_d;
    logic [15:0]            addr_q, addr_d;
    logic [15:0]            wdata_q, wdata_d;
    logic                   wr_q, wr_d;
    logic                   miso_q, miso_d;
    logic                   miso_oe_q, miso_oe_d;
    logic                   busy_q, busy_d;
    logic                   frame_err_q, frame_err_d;
`ifdef SPI_FRAME_PARITY_EN
    logic                   par_acc_q, par_acc_d;
    logic                   rd_par_q, rd_par_d;
    logic                   par_bad_q, par_bad_d;
`endif

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic active;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign active    = (state_q == ST_HEADER) || (state_q == ST_RD_WAIT) ||
                       (state_q == ST_DATA) || (state_q == ST_TAIL);

    assign o_miso      = miso_q;
    assign o_miso_oe   = miso_oe_q;
    assign o_addr      = addr_q;
    assign o_wdata     = wdata_q;
    assign o_wr        = wr_q;
    assign o_busy      = busy_q;
    assign o_frame_err = frame_err_q;

    // next-state logic: synchronisers, bit capture, MISO shifting and frame sequencing
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        miso_oe_d   = ~cs_s;
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        is_wr_d     = is_wr_q;
        wait_d      = wait_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        miso_d      = miso_q;
        busy_d      = busy_q;
        wr_d        = 1'b0;
        frame_err_d = 1'b0;
`ifdef SPI_FRAME_PARITY_EN
        par_acc_d   = par_acc_q;
        rd_par_d    = rd_par_q;
        par_bad_d   = par_bad_q;
`endif

        // Header and data bits share one 16-bit buffer: bit n lands at 15 - (n mod 16).
        if (active && sclk_rise) begin
            cnt_d = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;
            if (cnt_q < 6'd32) begin
                rx_d[4'd15 - cnt_q[3:0]] = mosi_s;
            end
`ifdef SPI_FRAME_PARITY_EN
            par_acc_d = par_acc_q ^ mosi_s;
`endif
        end

        // Fall k happens with k rises counted; read data occupies falls 16..31.
        if (active && sclk_fall) begin
            miso_d = 1'b0;
            if (!is_wr_q && (cnt_q >= 6'd16) && (cnt_q < 6'd32)) begin
                miso_d = tx_q[15];
                tx_d   = {tx_q[14:0], 1'b0};
            end
`ifdef SPI_FRAME_PARITY_EN
            if (!is_wr_q && (cnt_q == 6'd32)) begin
                miso_d = rd_par_q;
            end
`endif
        end

        unique case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    state_d = ST_HEADER;
                    cnt_d   = 6'd0;
                    is_wr_d = 1'b0;
                    busy_d  = 1'b1;
`ifdef SPI_FRAME_PARITY_EN
                    par_acc_d = 1'b0;
                    par_bad_d = 1'b0;
`endif
                end
            end
            ST_HEADER: begin
                if (sclk_rise && (cnt_d == 6'd16)) begin
                    state_d = ST_RD_WAIT;
                    addr_d  = {1'b0, rx_d[14:0]};
                    is_wr_d = rx_d[15];
                    wait_d  = 1'b0;
                end
            end
            ST_RD_WAIT: begin
                // First cycle lets the register bus see o_addr; second captures its data.
                if (!wait_q) begin
                    wait_d = 1'b1;
                end else begin
                    tx_d    = i_rdata;
                    state_d = ST_DATA;
`ifdef SPI_FRAME_PARITY_EN
                    rd_par_d = ~^i_rdata;
`endif
                end
            end
            ST_DATA: begin
                if (sclk_rise && (cnt_d == FRAME_CNT)) begin
                    state_d = ST_TAIL;
                    if (is_wr_q) begin
`ifdef SPI_FRAME_PARITY_EN
                        if (par_acc_d) begin
                            wr_d    = 1'b1;
                            wdata_d = rx_d;
                        end else begin
                            par_bad_d = 1'b1;
                        end
`else
                        wr_d    = 1'b1;
                        wdata_d = rx_d;
`endif
                    end
                end
            end
            ST_TAIL: begin
                state_d = ST_TAIL;
            end
            ST_WAIT_CS: begin
                if (cs_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_WAIT_CS;
            end
        endcase

        // CS release ends any frame; a commit landing on the same cycle still stands.
        if (active && cs_rise) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            miso_d  = 1'b0;
            if ((cnt_d != 6'd0) && (cnt_d < FRAME_CNT)) begin
                frame_err_d = 1'b1;
            end
`ifdef SPI_FRAME_PARITY_EN
            if (par_bad_d) begin
                frame_err_d = 1'b1;
            end
`endif
        end
    end

    // registers; CS synchroniser resets to "selected" so a frame in flight at reset is not taken as idle
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
            state_q     <= ST_WAIT_CS;
            cnt_q       <= 6'd0;
            rx_q        <= 16'h0;
            tx_q        <= 16'h0;
            is_wr_q     <= 1'b0;
            wait_q      <= 1'b0;
            addr_q      <= 16'h0;
            wdata_q     <= 16'h0;
            wr_q        <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef SPI_FRAME_PARITY_EN
            par_acc_q   <= 1'b0;
            rd_par_q    <= 1'b0;
            par_bad_q   <= 1'b0;
`endif
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            is_wr_q     <= is_wr_d;
            wait_q      <= wait_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
`ifdef SPI_FRAME_PARITY_EN
            par_acc_q   <= par_acc_d;
            rd_par_q    <= rd_par_d;
            par_bad_q   <= par_bad_d;
`endif
        end
    end

endmodule
